// File: rtl/multdiv_issue_pkg.sv
// Shared encodings for the mult/div issue path: FSM states, status register
// index and exception codes, reused by the bypass and hazard logic.
package multdiv_issue_pkg;
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_START = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam int STATUS_REG_DEF    = 30;
  localparam int MULT_EXC_CODE_DEF = 4;
  localparam int DIV_EXC_CODE_DEF  = 5;
  localparam int TIMEOUT_DEF       = 40;
endpackage

// File: rtl/multdiv_wait_counter.sv
// Cycle counter for the WAIT state; expired flags the last allowed WAIT cycle.
module multdiv_wait_counter #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (inc)  cnt_q <= cnt_q + 1'b1;
  end

  // Fires in the TIMEOUT-th WAIT cycle, so WAIT never lasts longer than TIMEOUT cycles.
  assign expired = inc && (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/multdiv_issue.sv
// Execute-stage issue/writeback controller for the shared multiplier and divider.
// Holds operands for the unit's whole iteration and redirects faults to the status register.
module multdiv_issue
  import multdiv_issue_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int REG_W         = 5,
  parameter int TIMEOUT       = TIMEOUT_DEF,
  parameter int STATUS_REG    = STATUS_REG_DEF,
  parameter int MULT_EXC_CODE = MULT_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE  = DIV_EXC_CODE_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_is_div,
  input  logic [DATA_W-1:0] req_opA,
  input  logic [DATA_W-1:0] req_opB,
  input  logic [REG_W-1:0]  req_rd,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] unit_opA,
  output logic [DATA_W-1:0] unit_opB,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  input  logic [DATA_W-1:0] unit_result,
  input  logic              unit_exception,
  input  logic              unit_resultRDY,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data
);
  state_t            state_q, state_d;
  logic              is_div_q, is_div_d;
  logic              exc_q, exc_d;
  logic [DATA_W-1:0] opA_q, opA_d, opB_q, opB_d, res_q, res_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              expired;

  multdiv_wait_counter #(.CNT_W(6), .TIMEOUT(TIMEOUT)) u_wait_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (state_q == S_START),
    .inc     (state_q == S_WAIT),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    exc_d    = exc_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    res_d    = res_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        opA_d    = req_opA;
        opB_d    = req_opB;
        rd_d     = req_rd;
        is_div_d = req_is_div;
        // Divide-by-zero never starts the divider.
        if (req_is_div && (req_opB == '0)) begin
          exc_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          exc_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A result arriving in the expiry cycle still counts.
        if (unit_resultRDY) begin
          res_d   = unit_result;
          exc_d   = unit_exception;
          state_d = S_DONE;
        end else if (expired) begin
          exc_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      exc_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
      opA_q    <= '0;
      opB_q    <= '0;
      res_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      exc_q    <= exc_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
    end
  end

  // The units read operand A combinationally every cycle, so only registered copies are exposed.
  assign unit_opA  = opA_q;
  assign unit_opB  = opB_q;
  assign busy      = (state_q != S_IDLE);
  assign stall     = ((state_q == S_IDLE) && req_valid) || (state_q == S_START) || (state_q == S_WAIT);
  assign ctrl_MULT = (state_q == S_START) && !is_div_q;
  assign ctrl_DIV  = (state_q == S_START) &&  is_div_q;
  assign wb_valid  = (state_q == S_DONE) && !flush;

  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    if (state_q == S_DONE) begin
      if (exc_q) begin
        wb_rd   = REG_W'(STATUS_REG);
        wb_data = is_div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
      end else begin
        wb_rd   = rd_q;
        wb_data = res_q;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_issue.sv
// Bench for multdiv_issue: table-driven ops with a writeback scoreboard and a
// behavioural mult/div unit, plus hand sequences for flush, operand hold and reset.
module tb_multdiv_issue;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0, req_valid = 1'b0, req_is_div = 1'b0;
  logic [31:0] req_opA = '0, req_opB = '0;
  logic [4:0]  req_rd = '0;
  logic        stall, busy, ctrl_MULT, ctrl_DIV, wb_valid;
  logic [31:0] unit_opA, unit_opB, wb_data;
  logic [31:0] unit_result = '0;
  logic        unit_exception = 1'b0, unit_resultRDY = 1'b0;
  logic [4:0]  wb_rd;

  multdiv_issue dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .req_valid(req_valid),
    .req_is_div(req_is_div), .req_opA(req_opA), .req_opB(req_opB), .req_rd(req_rd),
    .stall(stall), .busy(busy), .unit_opA(unit_opA), .unit_opB(unit_opB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .unit_result(unit_result),
    .unit_exception(unit_exception), .unit_resultRDY(unit_resultRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_div;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          delay;   // RDY this many cycles after ctrl_*, -1 = never
    bit          uexc;
    logic [4:0]  erd;
    logic [31:0] edata;
    int          estall;
    int          ectl;
  } vec_t;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

  wb_t         sb_q[$];
  int          checks = 0, errors = 0;
  int          stall_cnt = 0, cm_cnt = 0, cd_cnt = 0, wb_cnt = 0;
  bit          hold_en = 1'b0;
  logic [31:0] hold_a = '0;
  int          u_delay = -1, u_cnt = 0;
  bit          u_exc = 1'b0, u_act = 1'b0, u_div = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor and scoreboard consumer
  always @(negedge clock) begin
    if (stall) stall_cnt++;
    if (ctrl_MULT) cm_cnt++;
    if (ctrl_DIV) cd_cnt++;
    if (hold_en && busy) check("opA_hold", unit_opA, hold_a);
    if (wb_valid) begin
      wb_t e;
      wb_cnt++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%08h expected no writeback", wb_rd, wb_data);
      end else begin
        e = sb_q.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_data", wb_data, e.data);
      end
    end
  end

  // Behavioural unit: computes from the held operands at RDY time
  always @(negedge clock) begin
    unit_resultRDY = 1'b0;
    if (!reset_n) u_act = 1'b0;
    else if (ctrl_MULT || ctrl_DIV) begin
      u_act = (u_delay > 0);
      u_cnt = u_delay;
      u_div = ctrl_DIV;
    end else if (u_act) begin
      u_cnt--;
      if (u_cnt == 0) begin
        u_act          = 1'b0;
        unit_resultRDY = 1'b1;
        unit_exception = u_exc;
        unit_result    = u_div ? ((unit_opB != 0) ? unit_opA / unit_opB : 32'hDEAD)
                               : unit_opA * unit_opB;
      end
    end
  end

  task automatic drive_req(input bit d, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clock); #1;
    req_valid = 1'b1; req_is_div = d; req_opA = a; req_opB = b; req_rd = rd;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  wb0;
    bit  done;
    u_delay = v.delay; u_exc = v.uexc;
    sb_q.push_back('{rd: v.erd, data: v.edata});
    stall_cnt = 0; cm_cnt = 0; cd_cnt = 0;
    wb0 = wb_cnt; done = 1'b0;
    drive_req(v.is_div, v.a, v.b, v.rd);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      if (wb_cnt != wb0 && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL vec%0d_timeout: got no completion expected writeback within 100 cycles", idx);
    end
    check($sformatf("vec%0d_stall_cycles", idx), 32'(stall_cnt), 32'(v.estall));
    check($sformatf("vec%0d_ctrl_MULT", idx), 32'(cm_cnt), v.is_div ? 32'd0 : 32'(v.ectl));
    check($sformatf("vec%0d_ctrl_DIV", idx), 32'(cd_cnt), v.is_div ? 32'(v.ectl) : 32'd0);
    check($sformatf("vec%0d_wb_count", idx), 32'(wb_cnt - wb0), 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    int   wb0;
    bit   seen;
    vecs[0] = '{0, 32'd7,        32'hFFFFFFFD, 5'd5,  16, 0, 5'd5,  32'hFFFFFFEB, 18, 1};
    vecs[1] = '{1, 32'd100,      32'd0,        5'd9,  1,  0, 5'd30, 32'd5,        1,  0};
    vecs[2] = '{0, 32'h40000000, 32'd4,        5'd11, 3,  1, 5'd30, 32'd4,        5,  1};
    vecs[3] = '{1, 32'd50,       32'd3,        5'd7,  -1, 0, 5'd30, 32'd5,        42, 1};
    vecs[4] = '{1, 32'd100,      32'd7,        5'd0,  1,  0, 5'd0,  32'd14,       3,  1};
    vecs[5] = '{0, 32'h91,       32'h20,       5'd3,  40, 0, 5'd3,  32'h1220,     42, 1};
    vecs[6] = '{0, 32'd2,        32'd3,        5'd12, 5,  0, 5'd12, 32'd6,        7,  1};

    // Reset state
    @(negedge clock);
    check("rst_stall", 32'(stall), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_rd", 32'(wb_rd), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_unit_ops", unit_opA | unit_opB, 0);
    @(posedge clock); #1 reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Flush in WAIT, result arrives afterwards and must be dropped
    u_delay = 10; u_exc = 1'b0; cm_cnt = 0; wb0 = wb_cnt; seen = 1'b0;
    drive_req(0, 32'd9, 32'd9, 5'd4);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (cm_cnt != 0) seen = 1'b1;
    end
    check("flush_ctrl_seen", 32'(seen), 1);
    repeat (4) @(negedge clock);
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    check("flush_idle", 32'(busy), 0);
    repeat (12) @(negedge clock);
    check("flush_no_wb", 32'(wb_cnt - wb0), 0);
    check("flush_still_idle", 32'(busy), 0);
    run_vec(vecs[6], 6);

    // Flush during DONE of a divide-by-zero suppresses the status writeback
    wb0 = wb_cnt;
    @(posedge clock); #1;
    req_valid = 1'b1; req_is_div = 1'b1; req_opA = 32'd100; req_opB = 32'd0; req_rd = 5'd9;
    @(posedge clock); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clock);
    check("done_flush_wb_valid", 32'(wb_valid), 0);
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    check("done_flush_busy", 32'(busy), 0);
    check("done_flush_no_wb", 32'(wb_cnt - wb0), 0);
    run_vec(vecs[4], 4);

    // Operand hold while req_opA churns, then async reset mid-WAIT
    u_delay = -1; wb0 = wb_cnt;
    drive_req(1, 32'hAAAA0001, 32'd3, 5'd2);
    hold_a = 32'hAAAA0001; hold_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1 req_opA = $urandom;
    end
    #2 reset_n = 1'b0;
    #1;
    hold_en = 1'b0;
    check("arst_stall", 32'(stall), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_wb_valid", 32'(wb_valid), 0);
    check("arst_unit_opA", unit_opA, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("arst_no_wb", 32'(wb_cnt - wb0), 0);
    check("arst_idle", 32'(busy), 0);
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
